// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction fetch path.
//   INSTR_W      instruction word width
//   OPCODE_MSB/LSB  opcode field position inside the instruction word
//   fetch_state_t   fetch FSM encodings (FETCH_IDLE / FETCH_REQ)
package fetch_unit_pkg;

  localparam int INSTR_W    = 16;
  localparam int OPCODE_MSB = 15;
  localparam int OPCODE_LSB = 11;
  localparam int OPCODE_W   = OPCODE_MSB - OPCODE_LSB + 1;

  typedef enum logic {
    FETCH_IDLE = 1'b0,
    FETCH_REQ  = 1'b1
  } fetch_state_t;

  function automatic logic [OPCODE_W-1:0] get_opcode(input logic [INSTR_W-1:0] instr);
    return instr[OPCODE_MSB:OPCODE_LSB];
  endfunction

endpackage

// File: rtl/fetch_timeout_counter.sv
// Watchdog for an outstanding instruction-memory request.
// Counts cycles spent waiting in REQ; expired is high during the
// TIMEOUT_CYCLES-th consecutive waiting cycle.
// Ports:
//   clk, rst  clock / asynchronous active-high reset
//   clear     restart the count (asserted when a fetch is accepted)
//   run       the FSM is in REQ this cycle
//   expired   limit reached this cycle (combinational from the count)
module fetch_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic run,
  output logic expired
);

  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);

  logic [CNT_W-1:0] count_reg;

  assign expired = run && (count_reg == CNT_W'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (run && !expired) begin
      count_reg <= count_reg + CNT_W'(1);
    end
  end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit: owns the PC, fetches one 16-bit word per
// fetch_start over a req/ack handshake and holds it in IR for the
// microprogrammed control unit.
// Optional feature: define IMEM_TIMEOUT_EN to abort a request that sees no
// ack within TIMEOUT_CYCLES cycles and raise the sticky fault flag.
// Ports:
//   clk, rst            clock / asynchronous active-high reset
//   fetch_start         pulse: fetch the word at pc (ignored while busy)
//   pc_load, jmp_target load pc from jmp_target (any state)
//   imem_req, imem_addr request to instruction memory, held until ack
//   imem_rdata, imem_ack memory response
//   ir, opcode          instruction register and its opcode field
//   ir_valid            ir holds a word fetched since the last fetch_start
//   fetch_done          one-cycle pulse after a word is captured
//   busy                FSM not idle
//   pc                  program counter
//   fault               sticky fetch timeout flag (0 without IMEM_TIMEOUT_EN)
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int              PC_W           = 10,
  parameter logic [PC_W-1:0] RESET_PC       = '0,
  parameter int              TIMEOUT_CYCLES = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                fetch_start,
  input  logic                pc_load,
  input  logic [PC_W-1:0]     jmp_target,
  output logic                imem_req,
  output logic [PC_W-1:0]     imem_addr,
  input  logic [INSTR_W-1:0]  imem_rdata,
  input  logic                imem_ack,
  output logic [INSTR_W-1:0]  ir,
  output logic [OPCODE_W-1:0] opcode,
  output logic                ir_valid,
  output logic                fetch_done,
  output logic                busy,
  output logic [PC_W-1:0]     pc,
  output logic                fault
);

  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("fetch_unit: TIMEOUT_CYCLES must be at least 1");
  end

  fetch_state_t        state_reg;
  logic [PC_W-1:0]     pc_reg;
  logic [PC_W-1:0]     addr_reg;
  logic [INSTR_W-1:0]  ir_reg;
  logic                ir_valid_reg;
  logic                req_reg;
  logic                done_reg;
  logic                accept;
  logic                timeout_hit;

  assign accept = (state_reg == FETCH_IDLE) && fetch_start;

`ifdef IMEM_TIMEOUT_EN
  logic fault_reg;

  fetch_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk     (clk),
    .rst     (rst),
    .clear   (accept),
    .run     (state_reg == FETCH_REQ),
    .expired (timeout_hit)
  );

  // An ack in the limit cycle wins, so the fault only sets without ack.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fault_reg <= 1'b0;
    end else if (accept) begin
      fault_reg <= 1'b0;
    end else if (timeout_hit && !imem_ack) begin
      fault_reg <= 1'b1;
    end
  end

  assign fault = fault_reg;
`else
  assign timeout_hit = 1'b0;
  assign fault       = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg    <= FETCH_IDLE;
      pc_reg       <= RESET_PC;
      addr_reg     <= RESET_PC;
      ir_reg       <= '0;
      ir_valid_reg <= 1'b0;
      req_reg      <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      case (state_reg)
        FETCH_IDLE: begin
          if (fetch_start) begin
            state_reg    <= FETCH_REQ;
            req_reg      <= 1'b1;
            // A jump issued together with the fetch redirects the fetch itself.
            addr_reg     <= pc_load ? jmp_target : pc_reg;
            ir_valid_reg <= 1'b0;
          end
        end
        FETCH_REQ: begin
          if (imem_ack) begin
            state_reg    <= FETCH_IDLE;
            req_reg      <= 1'b0;
            ir_reg       <= imem_rdata;
            ir_valid_reg <= 1'b1;
            done_reg     <= 1'b1;
          end else if (timeout_hit) begin
            state_reg <= FETCH_IDLE;
            req_reg   <= 1'b0;
          end
        end
        default: begin
          state_reg <= FETCH_IDLE;
          req_reg   <= 1'b0;
        end
      endcase

      // pc_load beats the post-fetch increment; addr_reg is untouched so an
      // in-flight request keeps its address.
      if (pc_load) begin
        pc_reg <= jmp_target;
      end else if ((state_reg == FETCH_REQ) && imem_ack) begin
        pc_reg <= pc_reg + PC_W'(1);
      end
    end
  end

  assign imem_req   = req_reg;
  assign imem_addr  = addr_reg;
  assign ir         = ir_reg;
  assign opcode     = get_opcode(ir_reg);
  assign ir_valid   = ir_valid_reg;
  assign fetch_done = done_reg;
  assign busy       = (state_reg != FETCH_IDLE);
  assign pc         = pc_reg;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit. Inputs are driven and outputs sampled
// on the falling edge; the DUT works on the rising edge. Captured words are
// pushed to a scoreboard when the ack is driven and popped on fetch_done.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        fetch_start;
  logic        pc_load;
  logic [9:0]  jmp_target;
  logic        imem_req;
  logic [9:0]  imem_addr;
  logic [15:0] imem_rdata;
  logic        imem_ack;
  logic [15:0] ir;
  logic [4:0]  opcode;
  logic        ir_valid;
  logic        fetch_done;
  logic        busy;
  logic [9:0]  pc;
  logic        fault;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_start (fetch_start),
    .pc_load     (pc_load),
    .jmp_target  (jmp_target),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_rdata  (imem_rdata),
    .imem_ack    (imem_ack),
    .ir          (ir),
    .opcode      (opcode),
    .ir_valid    (ir_valid),
    .fetch_done  (fetch_done),
    .busy        (busy),
    .pc          (pc),
    .fault       (fault)
  );

  always #5 clk = ~clk;

  int          checks = 0;
  int          errors = 0;
  int          acks   = 0;
  int          dones  = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_exp;
  logic [9:0]  model_pc;
  logic [15:0] model_ir;
  logic [9:0]  addr;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Scoreboard consumer: every fetch_done must match one pushed word.
  always @(negedge clk) begin
    if (!rst && fetch_done) begin
      dones++;
      if (exp_q.size() == 0) begin
        check("done_spurious", 32'd1, 32'd0);
      end else begin
        mon_exp = exp_q.pop_front();
        check("done_ir", ir, mon_exp);
        check("done_opcode", opcode, mon_exp[15:11]);
        $display("fetch: ir=%h opcode=%b pc=%h", ir, opcode, pc);
      end
    end
  end

  task automatic start_fetch(input logic load, input logic [9:0] tgt, output logic [9:0] req_addr);
    fetch_start = 1'b1;
    pc_load     = load;
    jmp_target  = tgt;
    @(negedge clk);
    fetch_start = 1'b0;
    pc_load     = 1'b0;
    req_addr    = load ? tgt : model_pc;
    if (load) model_pc = tgt;
    check("start_req", imem_req, 1);
    check("start_addr", imem_addr, req_addr);
    check("start_busy", busy, 1);
    check("start_irvalid", ir_valid, 0);
    check("start_pc", pc, model_pc);
  endtask

  // Waits 'waits' cycles (pulsing fetch_start, optionally pc_load on the first),
  // then acks with 'data', optionally with pc_load in the ack cycle.
  task automatic finish_fetch(input logic [9:0] req_addr, input int waits, input logic [15:0] data,
                              input logic mid_load, input logic [9:0] mid_tgt,
                              input logic ack_load, input logic [9:0] ack_tgt);
    for (int i = 0; i < waits; i++) begin
      fetch_start = 1'b1;
      pc_load     = mid_load && (i == 0);
      jmp_target  = mid_tgt;
      @(negedge clk);
      fetch_start = 1'b0;
      pc_load     = 1'b0;
      if (mid_load && (i == 0)) model_pc = mid_tgt;
      check("wait_req", imem_req, 1);
      check("wait_addr", imem_addr, req_addr);
      check("wait_pc", pc, model_pc);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    pc_load    = ack_load;
    jmp_target = ack_tgt;
    exp_q.push_back(data);
    acks++;
    model_pc = ack_load ? ack_tgt : model_pc + 10'd1;
    model_ir = data;
    @(negedge clk);
    imem_ack   = 1'b0;
    pc_load    = 1'b0;
    imem_rdata = 16'($urandom);
    check("ack_req", imem_req, 0);
    check("ack_busy", busy, 0);
    check("ack_pc", pc, model_pc);
    check("ack_irvalid", ir_valid, 1);
    check("ack_ir", ir, model_ir);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; fetch_start = 1'b0; pc_load = 1'b0; jmp_target = '0;
    imem_rdata = '0; imem_ack = 1'b0;
    model_pc = 10'd0; model_ir = 16'd0;
    repeat (2) @(negedge clk);
    check("rst_req", imem_req, 0);
    check("rst_pc", pc, 0);
    check("rst_ir", ir, 0);
    check("rst_irvalid", ir_valid, 0);
    check("rst_done", fetch_done, 0);
    check("rst_busy", busy, 0);
    check("rst_fault", fault, 0);
    rst = 1'b0;
    @(negedge clk);

    // Zero-wait fetch from reset PC.
    start_fetch(1'b0, 10'd0, addr);
    check("first_addr", addr, 0);
    finish_fetch(addr, 0, 16'h3A05, 1'b0, 10'd0, 1'b0, 10'd0);
    check("first_opcode", opcode, 5'b00111);
    check("first_pc", pc, 10'd1);

    // Ack delayed 3 cycles, fetch_start pulses ignored meanwhile.
    start_fetch(1'b0, 10'd0, addr);
    finish_fetch(addr, 3, 16'hC123, 1'b0, 10'd0, 1'b0, 10'd0);

    // Jump together with fetch_start in IDLE.
    start_fetch(1'b1, 10'h155, addr);
    check("jmp_addr", imem_addr, 10'h155);
    finish_fetch(addr, 1, 16'h1234, 1'b0, 10'd0, 1'b0, 10'd0);
    check("jmp_pc", pc, 10'h156);

    // PC wraparound.
    start_fetch(1'b1, 10'h3FF, addr);
    finish_fetch(addr, 0, 16'hFFFF, 1'b0, 10'd0, 1'b0, 10'd0);
    check("wrap_pc", pc, 10'h000);

    // pc_load in the ack cycle overrides the increment.
    start_fetch(1'b0, 10'd0, addr);
    finish_fetch(addr, 2, 16'h8001, 1'b0, 10'd0, 1'b1, 10'h2AA);
    check("ackload_pc", pc, 10'h2AA);

    // pc_load mid-request: address held, pc follows the jump.
    start_fetch(1'b0, 10'd0, addr);
    finish_fetch(addr, 2, 16'h5A5A, 1'b1, 10'h011, 1'b0, 10'd0);
    check("midload_pc", pc, 10'h012);

    // Ack while idle is ignored.
    imem_ack = 1'b1; imem_rdata = 16'hDEAD;
    @(negedge clk);
    imem_ack = 1'b0;
    check("idleack_ir", ir, model_ir);
    check("idleack_pc", pc, model_pc);
    check("idleack_busy", busy, 0);

    // Random word / latency sweep.
    for (int k = 0; k < 4; k++) begin
      start_fetch(1'b0, 10'd0, addr);
      finish_fetch(addr, int'($urandom_range(0, 3)), 16'($urandom), 1'b0, 10'd0, 1'b0, 10'd0);
    end

`ifdef IMEM_TIMEOUT_EN
    // No ack for 16 cycles: request abandoned, fault set, state preserved.
    start_fetch(1'b0, 10'd0, addr);
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      check("to_wait_req", imem_req, 1);
    end
    @(negedge clk);
    check("to_req", imem_req, 0);
    check("to_busy", busy, 0);
    check("to_fault", fault, 1);
    check("to_pc", pc, model_pc);
    check("to_ir", ir, model_ir);
    start_fetch(1'b0, 10'd0, addr);
    check("to_fault_clear", fault, 0);
    finish_fetch(addr, 0, 16'h0F0F, 1'b0, 10'd0, 1'b0, 10'd0);
`else
    check("nofault", fault, 0);
`endif

    // Asynchronous reset in the middle of a request.
    start_fetch(1'b0, 10'd0, addr);
    #2 rst = 1'b1;
    #1;
    check("arst_req", imem_req, 0);
    check("arst_busy", busy, 0);
    check("arst_pc", pc, 0);
    check("arst_ir", ir, 0);
    check("arst_irvalid", ir_valid, 0);
    check("arst_done", fetch_done, 0);
    check("arst_fault", fault, 0);
    @(negedge clk);
    rst = 1'b0;
    model_pc = 10'd0; model_ir = 16'd0;
    repeat (2) @(negedge clk);
    check("post_arst_pc", pc, 0);

    check("done_count", dones, acks);
    check("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
